voltage_translator_seq: RTL and testbench
=========================================

Name: voltage_translator_seq

Overview:
Multi-channel enable sequencer for the tester's level translators. It replaces the single pass-through enable. Translators stay disabled except while input vectors are being applied.
- On a request, it enables a masked subset of channels and waits a settle time before flagging READY to the vector engine.
- It holds the channels on while the request persists, then disables them and waits out the settle time again before reporting completion.
- A watchdog forces the translators off if a request is held too long.

Parameters:
N_CH, 4, number of translator enable channels
SETTLE_CYC, 16, settle delay in clock cycles after enabling and after disabling; legal range 1..65535
MAX_ON_CYC, 1024, watchdog limit on cycles READY may stay high; 0 disables the watchdog; legal range 0..2^24-1

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST_N  input  1  synchronous active-low reset
REQ  input  1  level request to apply vectors; high = translators wanted on
CH_MASK  input  N_CH  channels to enable; sampled only on the IDLE->ENABLE transition
EN  output  N_CH  translator enables, registered
READY  output  1  high while the translators are enabled and settled
DONE  output  1  one-cycle pulse when a sequence returns to IDLE
TIMEOUT  output  1  sticky flag: watchdog fired
CLR_TIMEOUT  input  1  clears TIMEOUT

Behaviour:
- Reset: synchronous. A clock edge with RST_N=0 forces EN=0, READY=0, DONE=0, TIMEOUT=0, state=IDLE, counters=0, armed=1. This holds from any state, including mid-ENABLE or mid-ACTIVE. EN drops on that same edge, and no DONE is produced.
- All outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, ENABLE, ACTIVE, DISABLE.
- armed flag: cleared on every IDLE->ENABLE transition. Set on any edge where REQ=0.
- IDLE:
  - EN=0, READY=0.
  - If REQ=1, armed=1 and CH_MASK!=0, latch the mask, set EN=mask, clear the counter and go to ENABLE.
  - If CH_MASK=0, the request is ignored: stay IDLE with no flags.
- ENABLE:
  - Counter increments each cycle.
  - If REQ=0: EN<=0, counter cleared, go to DISABLE.
  - Else, on the edge where the counter reaches SETTLE_CYC-1: READY<=1 and go to ACTIVE.
  - Net effect: READY first rises SETTLE_CYC cycles after EN first rises.
- ACTIVE:
  - READY=1 and EN=latched mask.
  - The watchdog counter increments each cycle. It saturates and never wraps.
  - If REQ=0: EN<=0, READY<=0, go to DISABLE.
  - Else if MAX_ON_CYC!=0 and READY has been high for MAX_ON_CYC cycles: EN<=0, READY<=0, TIMEOUT<=1, go to DISABLE.
  - If both conditions occur on the same edge, REQ=0 wins and TIMEOUT is not set.
- DISABLE:
  - EN=0, READY=0.
  - Count SETTLE_CYC cycles, then go to IDLE with DONE<=1 for exactly one cycle.
  - REQ is ignored during DISABLE.
- Re-request: after a timeout, or after any sequence in which REQ stayed high, a new sequence starts only after REQ has been seen low for at least one cycle (armed). This prevents a stuck REQ from cycling the translators.
- TIMEOUT:
  - CLR_TIMEOUT=1 clears it on the next edge.
  - A set and a clear on the same edge leave it set (set wins).
  - It does not block new sequences.
- CH_MASK changes after latching have no effect until the next sequence.
- Counter widths are sized internally from the parameters using $clog2 of (value+1).

Test Plan:
- Basic sequence (SETTLE_CYC=16, MAX_ON_CYC=1024, CH_MASK=4'b0101): REQ high for 40 cycles then low -> EN=0101 one cycle after the REQ sample; READY high 16 cycles after EN rises; EN/READY drop one cycle after REQ falls; DONE pulses exactly 16 cycles later; TIMEOUT=0.
- Early abort: REQ high for 5 cycles -> EN=mask for 5 cycles; READY never asserts; DISABLE lasts 16 cycles; one DONE pulse.
- Watchdog (MAX_ON_CYC=8): REQ held high -> READY high exactly 8 cycles; EN drops with it; TIMEOUT=1; DONE after 16 cycles; no restart while REQ stays high; a restart occurs after REQ toggles low then high.
- Watchdog disabled (MAX_ON_CYC=0): REQ held 5000 cycles -> READY stays high throughout; TIMEOUT=0.
- Reset mid-ACTIVE: RST_N=0 for one cycle -> EN=0, READY=0 on that edge; no DONE; state IDLE; TIMEOUT cleared.
- Corner cases:
  - CH_MASK=0 with REQ high -> EN stays 0 and no DONE.
  - CLR_TIMEOUT asserted on the same edge the watchdog fires -> TIMEOUT=1.
  - CH_MASK changed during ACTIVE -> EN unchanged.

Source files
------------

// File: rtl/voltage_translator_seq.sv
// Enable sequencer for the level translators: masked channel enable, settle delays on both
// edges of a request, and a watchdog that forces the translators off if REQ is held too long.
module voltage_translator_seq #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned MAX_ON_CYC = 1024
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ,
  input  logic [N_CH-1:0] CH_MASK,
  output logic [N_CH-1:0] EN,
  output logic            READY,
  output logic            DONE,
  output logic            TIMEOUT,
  input  logic            CLR_TIMEOUT
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned WdW  = (MAX_ON_CYC == 0) ? 1 : $clog2(MAX_ON_CYC + 1);
  localparam bit          WdOn = (MAX_ON_CYC != 0);

  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  // Only meaningful when the watchdog is enabled.
  localparam logic [WdW-1:0]  WdLast     = WdW'(MAX_ON_CYC - 1);
  localparam logic [WdW-1:0]  WdOne      = WdW'(1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StEnable  = 2'd1;
  localparam logic [1:0] StActive  = 2'd2;
  localparam logic [1:0] StDisable = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [N_CH-1:0] en_q, en_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            armed_q, armed_d;
  logic            timeout_set;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    mask_d      = mask_q;
    en_d        = en_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    timeout_set = 1'b0;
    // Any cycle with REQ low re-arms, so a stuck REQ cannot cycle the translators.
    armed_d     = armed_q | ~REQ;

    case (state_q)
      StIdle: begin
        en_d    = '0;
        ready_d = 1'b0;
        if (REQ && armed_q && (|CH_MASK)) begin
          mask_d  = CH_MASK;
          en_d    = CH_MASK;
          cnt_d   = '0;
          armed_d = 1'b0;
          state_d = StEnable;
        end
      end
      StEnable: begin
        cnt_d = cnt_q + CntOne;
        if (!REQ) begin
          en_d    = '0;
          cnt_d   = '0;
          state_d = StDisable;
        end else if (cnt_q == SettleLast) begin
          ready_d = 1'b1;
          wd_d    = '0;
          state_d = StActive;
        end
      end
      StActive: begin
        wd_d = (&wd_q) ? wd_q : wd_q + WdOne;
        if (!REQ) begin
          en_d    = '0;
          ready_d = 1'b0;
          cnt_d   = '0;
          state_d = StDisable;
        end else if (WdOn && (wd_q == WdLast)) begin
          en_d        = '0;
          ready_d     = 1'b0;
          cnt_d       = '0;
          timeout_set = 1'b1;
          state_d     = StDisable;
        end
      end
      StDisable: begin
        en_d    = '0;
        ready_d = 1'b0;
        cnt_d   = cnt_q + CntOne;
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        en_d    = '0;
        ready_d = 1'b0;
        state_d = StIdle;
      end
    endcase

    // A watchdog fire outranks a simultaneous clear.
    timeout_d = timeout_set | (timeout_q & ~CLR_TIMEOUT);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wd_q      <= '0;
      mask_q    <= '0;
      en_q      <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wd_q      <= wd_d;
      mask_q    <= mask_d;
      en_q      <= en_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      armed_q   <= armed_d;
    end
  end

  assign EN      = en_q;
  assign READY   = ready_q;
  assign DONE    = done_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_voltage_translator_seq.sv
// Directed bench for voltage_translator_seq: three instances cover the default watchdog,
// a short watchdog (8 cycles) and a disabled watchdog, all sharing one clock and reset.
module tb_voltage_translator_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_w, req_z;
  logic [3:0] mask_a, mask_w, mask_z;
  logic       clr_a, clr_w, clr_z;
  logic [3:0] en_a, en_w, en_z;
  logic       ready_a, ready_w, ready_z;
  logic       done_a, done_w, done_z;
  logic       timeout_a, timeout_w, timeout_z;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  logic seen;

  always #5 clk = ~clk;

  voltage_translator_seq #(.N_CH(4), .SETTLE_CYC(16), .MAX_ON_CYC(1024)) dut_a (
    .CLK(clk), .RST_N(rst_n), .REQ(req_a), .CH_MASK(mask_a), .EN(en_a), .READY(ready_a),
    .DONE(done_a), .TIMEOUT(timeout_a), .CLR_TIMEOUT(clr_a)
  );

  voltage_translator_seq #(.N_CH(4), .SETTLE_CYC(16), .MAX_ON_CYC(8)) dut_w (
    .CLK(clk), .RST_N(rst_n), .REQ(req_w), .CH_MASK(mask_w), .EN(en_w), .READY(ready_w),
    .DONE(done_w), .TIMEOUT(timeout_w), .CLR_TIMEOUT(clr_w)
  );

  voltage_translator_seq #(.N_CH(4), .SETTLE_CYC(16), .MAX_ON_CYC(0)) dut_z (
    .CLK(clk), .RST_N(rst_n), .REQ(req_z), .CH_MASK(mask_z), .EN(en_z), .READY(ready_z),
    .DONE(done_z), .TIMEOUT(timeout_z), .CLR_TIMEOUT(clr_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 1'b0; req_w = 1'b0; req_z = 1'b0;
    mask_a = '0; mask_w = '0; mask_z = '0;
    clr_a = 1'b0; clr_w = 1'b0; clr_z = 1'b0;
    tick();
    tick();
    check("rst_en", 32'(en_a), 32'h0);
    check("rst_ready", 32'(ready_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_timeout", 32'(timeout_a), 32'h0);
    rst_n = 1'b1;

    // Basic sequence
    mask_a = 4'b0101;
    req_a  = 1'b1;
    tick();
    check("basic_en", 32'(en_a), 32'h5);
    check("basic_ready_lo", 32'(ready_a), 32'h0);
    cyc = 0;
    while (!ready_a && cyc < 100) begin tick(); cyc++; end
    check("basic_settle", 32'(cyc), 32'd16);
    repeat (10) tick();
    mask_a = 4'b1111;
    tick();
    check("mask_change_active", 32'(en_a), 32'h5);
    repeat (10) tick();
    req_a = 1'b0;
    tick();
    check("basic_en_off", 32'(en_a), 32'h0);
    check("basic_ready_off", 32'(ready_a), 32'h0);
    cyc = 0;
    while (!done_a && cyc < 100) begin tick(); cyc++; end
    check("basic_disable_len", 32'(cyc), 32'd16);
    tick();
    check("basic_done_pulse", 32'(done_a), 32'h0);
    check("basic_timeout", 32'(timeout_a), 32'h0);

    // Early abort
    mask_a = 4'b0011;
    req_a  = 1'b1;
    tick();
    check("abort_en", 32'(en_a), 32'h3);
    seen = 1'b0;
    repeat (4) begin tick(); seen |= ready_a; end
    check("abort_en_held", 32'(en_a), 32'h3);
    req_a = 1'b0;
    tick();
    seen |= ready_a;
    check("abort_ready_never", 32'(seen), 32'h0);
    check("abort_en_off", 32'(en_a), 32'h0);
    cyc = 0;
    while (!done_a && cyc < 100) begin tick(); cyc++; end
    check("abort_disable_len", 32'(cyc), 32'd16);

    // Zero mask is ignored
    mask_a = 4'b0000;
    req_a  = 1'b1;
    seen   = 1'b0;
    repeat (20) begin tick(); seen |= (|en_a) | done_a; end
    check("zero_mask_idle", 32'(seen), 32'h0);
    req_a = 1'b0;
    tick();

    // Watchdog with MAX_ON_CYC=8
    mask_w = 4'b1010;
    req_w  = 1'b1;
    tick();
    cyc = 0;
    while (!ready_w && cyc < 100) begin tick(); cyc++; end
    check("wd_settle", 32'(cyc), 32'd16);
    cyc = 0;
    while (ready_w && cyc < 100) begin tick(); cyc++; end
    check("wd_ready_len", 32'(cyc), 32'd8);
    check("wd_en_off", 32'(en_w), 32'h0);
    check("wd_timeout_set", 32'(timeout_w), 32'h1);
    cyc = 0;
    while (!done_w && cyc < 100) begin tick(); cyc++; end
    check("wd_disable_len", 32'(cyc), 32'd16);
    seen = 1'b0;
    repeat (40) begin tick(); seen |= |en_w; end
    check("wd_no_restart", 32'(seen), 32'h0);
    clr_w = 1'b1;
    tick();
    clr_w = 1'b0;
    check("wd_clear", 32'(timeout_w), 32'h0);
    req_w = 1'b0;
    tick();
    req_w = 1'b1;
    tick();
    check("wd_restart_en", 32'(en_w), 32'ha);
    cyc = 0;
    while (!ready_w && cyc < 100) begin tick(); cyc++; end
    check("wd_restart_settle", 32'(cyc), 32'd16);
    repeat (7) tick();
    check("wd_ready_before_fire", 32'(ready_w), 32'h1);
    clr_w = 1'b1;
    tick();
    clr_w = 1'b0;
    check("wd_set_beats_clear", 32'(timeout_w), 32'h1);
    check("wd_ready_fire", 32'(ready_w), 32'h0);
    cyc = 0;
    while (!done_w && cyc < 100) begin tick(); cyc++; end
    req_w = 1'b0;

    // Watchdog disabled
    mask_z = 4'b1111;
    req_z  = 1'b1;
    tick();
    cyc = 0;
    while (!ready_z && cyc < 100) begin tick(); cyc++; end
    check("nowd_settle", 32'(cyc), 32'd16);
    seen = 1'b0;
    repeat (5000) begin tick(); seen |= ~ready_z; end
    check("nowd_ready_held", 32'(seen), 32'h0);
    check("nowd_timeout", 32'(timeout_z), 32'h0);

    // Reset mid-ACTIVE
    rst_n = 1'b0;
    tick();
    check("rst_mid_en", 32'(en_z), 32'h0);
    check("rst_mid_ready", 32'(ready_z), 32'h0);
    check("rst_mid_done", 32'(done_z), 32'h0);
    check("rst_clears_timeout", 32'(timeout_w), 32'h0);
    rst_n = 1'b1;
    req_z = 1'b0;
    seen  = 1'b0;
    repeat (20) begin tick(); seen |= done_z | (|en_z); end
    check("rst_no_done", 32'(seen), 32'h0);
    req_z = 1'b1;
    tick();
    check("rst_idle_restart", 32'(en_z), 32'hf);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
